// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI configuration-register slave.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  localparam int ADDR_EN_OUT_LO = 'h00;
  localparam int ADDR_EN_OUT_HI = 'h01;
  localparam int ADDR_EN_PWM_LO = 'h02;
  localparam int ADDR_EN_PWM_HI = 'h03;
  localparam int ADDR_PWM_DUTY  = 'h04;
  localparam int NUM_REGS       = 5;

  localparam int FRAME_BITS = 16;
  // Bit counter stops one past a full frame so long frames stay distinguishable.
  localparam logic [4:0] CNT_SAT = 5'd17;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, plus a previous-value
// register that provides single-cycle rise/fall flags in the clk domain.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only slave: deserialises 16-bit frames and commits the data
// byte into one of five configuration registers, or flags the frame as bad.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic sclk_rise, copi_level, ncs_level, ncs_rise, ncs_fall;
  logic sclk_level_unused, sclk_fall_unused, copi_rise_unused, copi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .async_in(copi),
    .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_in(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_e                      state_q, state_d;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic                        commit_q, commit_d;
  logic                        err_q, err_d;
  logic [6:0]                  pend_addr_q, pend_addr_d;
  logic [7:0]                  pend_data_q, pend_data_d;
  logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic                        frame_err_q, frame_err_d;
  logic                        frame_ok;

  assign frame_ok = (cnt_q == 5'(FRAME_BITS)) && shift_q[15] &&
                    (int'(shift_q[14:8]) <= MAX_ADDR);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    commit_d    = 1'b0;
    err_d       = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    regs_d      = regs_q;
    wr_strobe_d = commit_q;
    frame_err_d = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Frame end takes priority: an sclk edge coincident with ncs rise is dropped.
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise && !ncs_level) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
          if (cnt_q < CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        commit_d    = frame_ok;
        err_d       = !frame_ok;
        pend_addr_d = shift_q[14:8];
        pend_data_d = shift_q[7:0];
        // A new frame may already be starting; do not lose its falling edge.
        if (ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_q && (pend_addr_q == 7'(i))) regs_d[i] = pend_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;

endmodule
